// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide sequencer.
//   md_op_e  : MD_Op encodings carried on the E-stage bus
//   state_e  : sequencer FSM states
//   DATA_W   : operand / HI / LO width
//   CNT_W    : latency counter width (latencies 1..15)
//   *_LAT_DEF: default operation latencies
//   is_arith / is_mult : helpers to classify an MD_Op
package md_pkg;

  localparam int DATA_W       = 32;
  localparam int CNT_W        = 4;
  localparam int MULT_LAT_DEF = 5;
  localparam int DIV_LAT_DEF  = 10;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6,
    MD_RSVD  = 3'd7
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Operations that occupy the unit for a multi-cycle latency.
  function automatic logic is_arith(md_op_e op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_mult(md_op_e op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

endpackage

// File: rtl/md_sequencer_if.sv
// E-stage to multiply/divide unit bus.
//   Start  : E-stage MD op valid this cycle
//   MD_Op  : operation code (md_op_e encoding)
//   A, B   : forwarded rs / rt values
//   cancel : squash in-flight op, drop any op presented in IDLE
//   Busy   : operation in progress
//   HI, LO : architectural HI/LO registers
// master = pipeline side, slave = sequencer side.
interface md_sequencer_if;
  import md_pkg::*;

  logic              Start;
  logic [2:0]        MD_Op;
  logic [DATA_W-1:0] A;
  logic [DATA_W-1:0] B;
  logic              cancel;
  logic              Busy;
  logic [DATA_W-1:0] HI;
  logic [DATA_W-1:0] LO;

  modport master (
    output Start, MD_Op, A, B, cancel,
    input  Busy, HI, LO
  );

  modport slave (
    input  Start, MD_Op, A, B, cancel,
    output Busy, HI, LO
  );

endinterface

// File: rtl/md_core.sv
// Combinational multiply/divide datapath working on latched operands.
//   op     : operation (only MULT/MULTU/DIV/DIVU produce a result)
//   a, b   : latched operands
//   hi_res : HI result (product high word / remainder)
//   lo_res : LO result (product low word / quotient)
// Divide by zero yields HI=a, LO=all ones; signed overflow (MIN / -1)
// yields LO=MIN, HI=0.
module md_core
  import md_pkg::*;
(
  input  md_op_e            op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] hi_res,
  output logic [DATA_W-1:0] lo_res
);

  logic signed [2*DATA_W-1:0] a_ext;
  logic signed [2*DATA_W-1:0] b_ext;
  logic signed [2*DATA_W-1:0] prod_s;
  logic        [2*DATA_W-1:0] prod_u;
  logic                       div_zero;
  logic                       div_ovf;
  logic signed [DATA_W-1:0]   num_s;
  logic signed [DATA_W-1:0]   den_s;
  logic signed [DATA_W-1:0]   quot_s;
  logic signed [DATA_W-1:0]   rem_s;
  logic        [DATA_W-1:0]   den_u;
  logic        [DATA_W-1:0]   quot_u;
  logic        [DATA_W-1:0]   rem_u;

  always_comb begin
    a_ext    = {{DATA_W{a[DATA_W-1]}}, a};
    b_ext    = {{DATA_W{b[DATA_W-1]}}, b};
    prod_s   = a_ext * b_ext;
    prod_u   = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};

    div_zero = (b == '0);
    div_ovf  = (a == {1'b1, {(DATA_W-1){1'b0}}}) && (b == '1);

    // The divider never sees a zero or overflowing divisor; those cases are
    // overridden below, so a harmless divisor of 1 keeps the dividers defined.
    num_s    = a;
    den_s    = (div_zero || div_ovf) ? DATA_W'(1) : b;
    quot_s   = num_s / den_s;
    rem_s    = num_s % den_s;
    den_u    = div_zero ? DATA_W'(1) : b;
    quot_u   = a / den_u;
    rem_u    = a % den_u;

    hi_res   = '0;
    lo_res   = '0;
    case (op)
      MD_MULT:  {hi_res, lo_res} = prod_s;
      MD_MULTU: {hi_res, lo_res} = prod_u;
      MD_DIV: begin
        if (div_zero) begin
          hi_res = a;
          lo_res = '1;
        end else if (div_ovf) begin
          hi_res = '0;
          lo_res = {1'b1, {(DATA_W-1){1'b0}}};
        end else begin
          hi_res = rem_s;
          lo_res = quot_s;
        end
      end
      MD_DIVU: begin
        if (div_zero) begin
          hi_res = a;
          lo_res = '1;
        end else begin
          hi_res = rem_u;
          lo_res = quot_u;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/md_sequencer.sv
// Multiply/divide sequencer for the EXE stage; owns HI/LO.
//   clk   : system clock, rising edge
//   reset : synchronous active-high reset (control, operands and HI/LO)
//   bus   : md_sequencer_if.slave (Start, MD_Op, A, B, cancel -> Busy, HI, LO)
// A MULT/MULTU/DIV/DIVU accepted in IDLE latches its operands and keeps
// Busy high for MULT_LAT / DIV_LAT cycles, committing HI/LO on the last
// edge. MTHI/MTLO write A directly, only while IDLE. cancel squashes
// whatever is in flight or presented without touching HI/LO.
module md_sequencer
  import md_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF
) (
  input  logic          clk,
  input  logic          reset,
  md_sequencer_if.slave bus
);

  localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_LAT - 1);

  state_e            state;
  state_e            state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic              load;
  logic              commit;
  logic              wr_hi;
  logic              wr_lo;
  md_op_e            op_in;
  md_op_e            op_p0;
  logic [DATA_W-1:0] a_p0;
  logic [DATA_W-1:0] b_p0;
  logic [DATA_W-1:0] hi_q;
  logic [DATA_W-1:0] lo_q;
  logic [DATA_W-1:0] hi_res;
  logic [DATA_W-1:0] lo_res;

  assign op_in = md_op_e'(bus.MD_Op);

  // Counter preload so that Busy spans exactly LAT cycles.
  function automatic logic [CNT_W-1:0] lat_cnt(md_op_e op);
    return is_mult(op) ? MULT_CNT : DIV_CNT;
  endfunction

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    load      = 1'b0;
    commit    = 1'b0;
    wr_hi     = 1'b0;
    wr_lo     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!bus.cancel) begin
          if (bus.Start && is_arith(op_in)) begin
            load      = 1'b1;
            cnt_nxt   = lat_cnt(op_in);
            state_nxt = ST_RUN;
          end else if (op_in == MD_MTHI) begin
            wr_hi = 1'b1;
          end else if (op_in == MD_MTLO) begin
            wr_lo = 1'b1;
          end
        end
      end
      ST_RUN: begin
        // A Start or MTHI/MTLO seen here is ignored; the hazard stall
        // upstream is expected to keep them away.
        if (bus.cancel) begin
          cnt_nxt   = '0;
          state_nxt = ST_IDLE;
        end else if (cnt == '0) begin
          commit    = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Stage p0: operand latch feeding the combinational core
  always_ff @(posedge clk) begin
    if (reset) begin
      op_p0 <= MD_NONE;
      a_p0  <= '0;
      b_p0  <= '0;
    end else if (load) begin
      op_p0 <= op_in;
      a_p0  <= bus.A;
      b_p0  <= bus.B;
    end
  end

  md_core u_core (
    .op     (op_p0),
    .a      (a_p0),
    .b      (b_p0),
    .hi_res (hi_res),
    .lo_res (lo_res)
  );

  // Architectural HI/LO: commit and MTHI/MTLO are mutually exclusive by state
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (commit) begin
      hi_q <= hi_res;
      lo_q <= lo_res;
    end else begin
      if (wr_hi) hi_q <= bus.A;
      if (wr_lo) lo_q <= bus.A;
    end
  end

  assign bus.Busy = (state == ST_RUN);
  assign bus.HI   = hi_q;
  assign bus.LO   = lo_q;

endmodule

// File: tb/tb_md_sequencer.sv
// Self-checking bench for md_sequencer. Each accepted operation pushes its
// expected HI/LO and Busy length; a negedge monitor pops an entry whenever
// Busy falls and also checks HI/LO stay put while Busy is high.
module tb_md_sequencer;
  import md_pkg::*;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          len;
  } exp_t;

  logic clk;
  logic reset;
  md_sequencer_if bus ();

  md_sequencer #(.MULT_LAT(5), .DIV_LAT(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t        sb[$];
  logic [31:0] m_hi;
  logic [31:0] m_lo;
  int          n_chk;
  int          n_err;
  int          busy_len;
  int          illegal_start;
  int          illegal_mt;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Monitor: Busy length, HI/LO hold during RUN, results on Busy fall,
  // and occurrences of ops the hazard controller should have stalled.
  always @(negedge clk) begin
    exp_t e;
    if (bus.Busy === 1'b1) begin
      busy_len++;
      chk("hold_hi", bus.HI, m_hi);
      chk("hold_lo", bus.LO, m_lo);
      if (bus.Start && bus.MD_Op >= 3'd1 && bus.MD_Op <= 3'd4) illegal_start++;
      if ((bus.MD_Op == 3'd5 || bus.MD_Op == 3'd6) && !bus.cancel) illegal_mt++;
    end else if (busy_len > 0) begin
      if (sb.size() == 0) begin
        chk("unexpected_busy_fall", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("busy_len", busy_len, e.len);
        chk("result_hi", bus.HI, e.hi);
        chk("result_lo", bus.LO, e.lo);
        m_hi = e.hi;
        m_lo = e.lo;
      end
      busy_len = 0;
    end
  end

  function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] hi, output logic [31:0] lo);
    int              sa, sb_;
    longint          p;
    longint unsigned pu;
    sa  = a;
    sb_ = b;
    hi  = 0;
    lo  = 0;
    case (op)
      3'd1: begin p = longint'(sa) * longint'(sb_); hi = p[63:32]; lo = p[31:0]; end
      3'd2: begin pu = {32'h0, a} * {32'h0, b}; hi = pu[63:32]; lo = pu[31:0]; end
      3'd3: begin
        if (b == 0) begin hi = a; lo = 32'hFFFF_FFFF; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin hi = 0; lo = 32'h8000_0000; end
        else begin hi = sa % sb_; lo = sa / sb_; end
      end
      3'd4: begin
        if (b == 0) begin hi = a; lo = 32'hFFFF_FFFF; end
        else begin hi = a % b; lo = a / b; end
      end
      default: ;
    endcase
  endfunction

  // Start at the next edge N; returns in cycle N+1 (first Busy cycle).
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] hi, input logic [31:0] lo);
    exp_t e;
    @(posedge clk); #1;
    bus.Start = 1'b1;
    bus.MD_Op = op;
    bus.A     = a;
    bus.B     = b;
    e.hi  = hi;
    e.lo  = lo;
    e.len = (op == 3'd1 || op == 3'd2) ? 5 : 10;
    sb.push_back(e);
    @(posedge clk); #1;
    bus.Start = 1'b0;
    bus.MD_Op = 3'd0;
  endtask

  task automatic issue_m(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] hi, lo;
    model(op, a, b, hi, lo);
    issue(op, a, b, hi, lo);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && (bus.Busy || sb.size() != 0); i++) begin
      @(posedge clk); #2;
    end
    if (bus.Busy || sb.size() != 0) chk("wait_idle_timeout", 1, 0);
  endtask

  // Replace the in-flight expectation: squashed ops keep (or clear) HI/LO.
  task automatic squash_back(input logic [31:0] hi, input logic [31:0] lo, input int len);
    exp_t e;
    if (sb.size() == 0) begin
      chk("squash_no_entry", 1, 0);
    end else begin
      e = sb.pop_back();
      e.hi  = hi;
      e.lo  = lo;
      e.len = len;
      sb.push_back(e);
    end
  endtask

  initial begin
    n_chk = 0; n_err = 0; busy_len = 0; illegal_start = 0; illegal_mt = 0;
    m_hi = 0; m_lo = 0;
    bus.Start = 0; bus.MD_Op = 0; bus.A = 0; bus.B = 0; bus.cancel = 0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("reset_busy", bus.Busy, 0);
    chk("reset_hi", bus.HI, 0);
    chk("reset_lo", bus.LO, 0);

    // Spec vectors with hard expectations
    issue(3'd1, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    wait_idle();
    issue(3'd4, 32'd100, 32'd7, 32'd2, 32'd14);
    wait_idle();
    issue(3'd3, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    wait_idle();
    issue(3'd3, 32'h1234_5678, 32'd0, 32'h1234_5678, 32'hFFFF_FFFF);
    wait_idle();
    issue(3'd4, 32'hCAFE_0001, 32'd0, 32'hCAFE_0001, 32'hFFFF_FFFF);
    wait_idle();
    issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
    wait_idle();

    // A few random operations through the reference model
    for (int i = 0; i < 6; i++) begin
      issue_m(3'((i % 4) + 1), $urandom, (i == 5) ? 32'd3 : $urandom);
      wait_idle();
    end

    // Reserved/none op codes with Start, and Start+cancel in IDLE, do nothing
    @(posedge clk); #1 bus.Start = 1; bus.MD_Op = 3'd7;
    @(posedge clk); #1 bus.MD_Op = 3'd0;
    @(posedge clk); #1 bus.Start = 0;
    chk("op_rsvd_idle", bus.Busy, 0);
    bus.Start = 1; bus.MD_Op = 3'd1; bus.cancel = 1;
    @(posedge clk); #1 bus.Start = 0; bus.MD_Op = 0; bus.cancel = 0;
    chk("start_cancel_idle", bus.Busy, 0);
    bus.MD_Op = 3'd6; bus.A = 32'h5555_AAAA; bus.cancel = 1;
    @(posedge clk); #1 bus.MD_Op = 0; bus.cancel = 0;
    chk("mtlo_cancel_lo", bus.LO, m_lo);

    // Cancel at RUN cycle 3, with an illegal Start during RUN cycle 1
    issue(3'd1, 32'd11, 32'd13, 32'd0, 32'd143);
    bus.Start = 1; bus.MD_Op = 3'd3; bus.A = 32'd99; bus.B = 32'd1;
    @(posedge clk); #1 bus.Start = 0; bus.MD_Op = 0;
    @(posedge clk); #1 bus.cancel = 1;
    squash_back(m_hi, m_lo, 3);
    @(posedge clk); #1 bus.cancel = 0;
    chk("cancel_busy", bus.Busy, 0);
    wait_idle();
    chk("illegal_start_seen", illegal_start, 1);

    // MTHI in IDLE
    bus.MD_Op = 3'd5; bus.A = 32'h0000_1234;
    @(posedge clk); #1 bus.MD_Op = 0; bus.A = 0;
    chk("mthi_hi", bus.HI, 32'h0000_1234);
    m_hi = 32'h0000_1234;

    // MULTU with operands toggling while running
    issue(3'd2, 32'hFFFF_FFFF, 32'd2, 32'd1, 32'hFFFF_FFFE);
    for (int i = 0; i < 6; i++) begin
      bus.A = $urandom; bus.B = $urandom;
      @(posedge clk); #1;
    end
    wait_idle();

    // Reset at RUN cycle 2 discards everything
    issue(3'd3, 32'd1000, 32'd3, 32'd1, 32'd333);
    @(posedge clk); #1 reset = 1;
    squash_back(32'd0, 32'd0, 2);
    @(posedge clk); #1 reset = 0;
    chk("midrun_reset_busy", bus.Busy, 0);
    chk("midrun_reset_hi", bus.HI, 0);
    chk("midrun_reset_lo", bus.LO, 0);
    wait_idle();

    // Post-reset operation still works
    issue_m(3'd1, 32'h8000_0000, 32'h8000_0000);
    wait_idle();

    chk("illegal_mt_seen", illegal_mt, 0);
    chk("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
